// File: rtl/lcd1602_bus_monitor.sv
// lcd1602_bus_monitor
// Receive-side model of the HD44780/LCD1602 parallel bus. Decodes each enable
// falling edge into an instruction or a character write, keeps a 32-entry
// shadow of the visible display plus the display-control state, and exposes
// the shadow through a registered read port.
//
// Optional feature macro: LCD1602_TIMING_CHECK_EN
//   defined   : short enable pulses raise pulse_err, every command/data write
//               emulates BUSY_CYCLES of execution, strobes while busy raise
//               busy_err.
//   undefined : every falling edge is accepted, only clear is timed, strobes
//               during clear are dropped silently, pulse_err/busy_err stay 0.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   rs, rw, enable, data: LCD bus as driven by the controller (sampled only)
//   rd_idx / rd_char    : shadow read port {line, column}, one-cycle latency
//   cmd_valid, cmd_code : accepted instruction pulse and its byte
//   char_valid, char_data, char_addr : accepted data write pulse, byte, address
//   addr                : DDRAM address counter
//   display_on, cursor_on, blink_on, entry_inc, two_line : control state
//   busy                : model executing (clear or busy emulation)
//   pulse_err, busy_err, rw_seen : one-cycle event pulses

module lcd1602_bus_monitor #(
   parameter int unsigned MIN_EN_HIGH  = 4,
   parameter int unsigned BUSY_CYCLES  = 8,
   parameter int unsigned CLEAR_CYCLES = 40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rs,
   input  logic       rw,
   input  logic       enable,
   input  logic [7:0] data,
   input  logic [4:0] rd_idx,
   output logic [7:0] rd_char,
   output logic       cmd_valid,
   output logic [7:0] cmd_code,
   output logic       char_valid,
   output logic [7:0] char_data,
   output logic [6:0] char_addr,
   output logic [6:0] addr,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       entry_inc,
   output logic       two_line,
   output logic       busy,
   output logic       pulse_err,
   output logic       busy_err,
   output logic       rw_seen
);

`ifdef LCD1602_TIMING_CHECK_EN
   localparam bit TIMING_CHECK = 1'b1;
`else
   localparam bit TIMING_CHECK = 1'b0;
`endif

   localparam int unsigned BUS_W   = 11;
   localparam int unsigned DEPTH   = 32;
   localparam int unsigned CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned HC_W    = $clog2(MIN_EN_HIGH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      BUSY  = 2'd2
   } state_t;

   state_t state, state_next;

   // bus bit layout: [10] rs, [9] rw, [8] enable, [7:0] data
   logic [BUS_W-1:0] sync1, sync2, align;
   logic             fall;
   logic [HC_W-1:0]  hcnt;

   logic       stb, stb_rs, stb_rw, stb_short;
   logic [7:0] stb_data;

   logic do_rw, do_drop, is_cmd, is_chr, is_clear;

   logic [CNT_W-1:0] cnt;

   logic [7:0] shadow [DEPTH];
   logic       wr_en;
   logic [4:0] wr_idx;
   logic [7:0] wr_data;

   // Two-flop synchronizer followed by one alignment stage
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         align <= '0;
      end else begin
         sync1 <= {rs, rw, enable, data};
         sync2 <= sync1;
         align <= sync2;
      end
   end

   assign fall = !sync2[8] && align[8];

   // Enable-high width, saturating at MIN_EN_HIGH
   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt <= '0;
      end else if (fall) begin
         hcnt <= '0;
      end else if (sync2[8] && (hcnt < HC_W'(MIN_EN_HIGH))) begin
         hcnt <= hcnt + HC_W'(1);
      end
   end

   // Strobe stage: the aligned copy still holds the values seen while enable was high
   always_ff @(posedge clk) begin
      if (reset) begin
         stb       <= 1'b0;
         stb_rs    <= 1'b0;
         stb_rw    <= 1'b0;
         stb_short <= 1'b0;
         stb_data  <= '0;
      end else begin
         stb <= fall;
         if (fall) begin
            stb_rs    <= align[10];
            stb_rw    <= align[9];
            stb_data  <= align[7:0];
            stb_short <= (hcnt < HC_W'(MIN_EN_HIGH));
         end
      end
   end

   // Strobe classification
   always_comb begin
      logic strobe_ok;
      logic xfer;
      strobe_ok = stb && !(TIMING_CHECK && stb_short);
      xfer      = strobe_ok && !stb_rw;
      do_rw     = strobe_ok && stb_rw;
      do_drop   = xfer && (state != IDLE);
      is_cmd    = xfer && (state == IDLE) && !stb_rs;
      is_chr    = xfer && (state == IDLE) && stb_rs;
      is_clear  = is_cmd && (stb_data == 8'h01);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next state
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (is_clear)                                state_next = CLEAR;
            else if (TIMING_CHECK && (is_cmd || is_chr)) state_next = BUSY;
         end
         CLEAR: if (cnt == CNT_W'(CLEAR_CYCLES - 1)) state_next = IDLE;
         BUSY:  if (cnt <= CNT_W'(1))                state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = 1'b0;
      if (state != IDLE) busy = 1'b1;
   end

   // Clear counts up (fill index, then wait); busy emulation counts down
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         unique case (state)
            IDLE:    cnt <= is_clear ? '0 : CNT_W'(BUSY_CYCLES);
            CLEAR:   cnt <= cnt + CNT_W'(1);
            BUSY:    cnt <= cnt - CNT_W'(1);
            default: cnt <= '0;
         endcase
      end
   end

   // Two-line address stepping: wraps line ends into the other line
   function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
      logic [6:0] n;
      if (up) begin
         if (a == 7'h27)      n = 7'h40;
         else if (a == 7'h67) n = 7'h00;
         else                 n = a + 7'd1;
      end else begin
         if (a == 7'h40)      n = 7'h27;
         else if (a == 7'h00) n = 7'h67;
         else                 n = a - 7'd1;
      end
      return n;
   endfunction

   // Control state, address counter and event pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_valid  <= 1'b0;
         char_valid <= 1'b0;
         rw_seen    <= 1'b0;
         busy_err   <= 1'b0;
         pulse_err  <= 1'b0;
         cmd_code   <= '0;
         char_data  <= '0;
         char_addr  <= '0;
         addr       <= '0;
         display_on <= 1'b0;
         cursor_on  <= 1'b0;
         blink_on   <= 1'b0;
         two_line   <= 1'b0;
         entry_inc  <= 1'b1;
      end else begin
         cmd_valid  <= is_cmd;
         char_valid <= is_chr;
         rw_seen    <= do_rw;
         busy_err   <= TIMING_CHECK && do_drop;
         pulse_err  <= TIMING_CHECK && stb && stb_short;

         if (is_cmd) begin
            cmd_code <= stb_data;
            if (stb_data[7]) begin
               addr <= stb_data[6:0];
            end else if (stb_data[6]) begin
               // CGRAM address: not modelled
            end else if (stb_data[5]) begin
               two_line <= stb_data[3];
            end else if (stb_data[4]) begin
               if (!stb_data[3]) addr <= step_addr(addr, stb_data[2]);
            end else if (stb_data[3]) begin
               display_on <= stb_data[2];
               cursor_on  <= stb_data[1];
               blink_on   <= stb_data[0];
            end else if (stb_data[2]) begin
               entry_inc <= stb_data[1];
            end else if (stb_data[1]) begin
               addr <= '0;
            end else if (stb_data[0]) begin
               addr      <= '0;
               entry_inc <= 1'b1;
            end
         end

         if (is_chr) begin
            char_data <= stb_data;
            char_addr <= addr;
            addr      <= step_addr(addr, entry_inc);
         end
      end
   end

   // Shadow write port: clear fill or a visible-window data write
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = '0;
      wr_data = '0;
      if (!reset) begin
         if ((state == CLEAR) && (cnt < CNT_W'(DEPTH))) begin
            wr_en   = 1'b1;
            wr_idx  = cnt[4:0];
            wr_data = 8'h20;
         end else if (is_chr && (addr[5:4] == 2'b00)) begin
            wr_en   = 1'b1;
            wr_idx  = {addr[6], addr[3:0]};
            wr_data = stb_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) shadow[wr_idx] <= wr_data;
   end

   // Registered read; same-cycle write returns the old value
   always_ff @(posedge clk) begin
      if (reset) rd_char <= '0;
      else       rd_char <= shadow[rd_idx];
   end

endmodule

// File: tb/tb_lcd1602_bus_monitor.sv
// Self-checking bench for lcd1602_bus_monitor: directed and randomized bus
// strobes, a behavioural reference model, and a scoreboard monitor that
// checks every event pulse against the expected queue.

module tb_lcd1602_bus_monitor;

   localparam int unsigned MIN_EN_HIGH  = 4;
   localparam int unsigned BUSY_CYCLES  = 8;
   localparam int unsigned CLEAR_CYCLES = 40;

`ifdef LCD1602_TIMING_CHECK_EN
   localparam bit TCHK = 1'b1;
`else
   localparam bit TCHK = 1'b0;
`endif

   localparam logic [4:0] K_CMD = 5'd1, K_CHR = 5'd2, K_RW = 5'd4, K_BERR = 5'd8, K_PERR = 5'd16;

   logic       clk = 1'b0;
   logic       reset, rs, rw, enable;
   logic [7:0] data;
   logic [4:0] rd_idx;
   logic [7:0] rd_char, cmd_code, char_data;
   logic [6:0] char_addr, addr;
   logic       cmd_valid, char_valid, display_on, cursor_on, blink_on;
   logic       entry_inc, two_line, busy, pulse_err, busy_err, rw_seen;

   lcd1602_bus_monitor #(
      .MIN_EN_HIGH (MIN_EN_HIGH),
      .BUSY_CYCLES (BUSY_CYCLES),
      .CLEAR_CYCLES(CLEAR_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable), .data(data),
      .rd_idx(rd_idx), .rd_char(rd_char), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .char_valid(char_valid), .char_data(char_data), .char_addr(char_addr), .addr(addr),
      .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
      .entry_inc(entry_inc), .two_line(two_line), .busy(busy),
      .pulse_err(pulse_err), .busy_err(busy_err), .rw_seen(rw_seen)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0] kind;
      int         at;
      logic [7:0] d;
      logic [6:0] a;
      logic       bsy;
   } ev_t;

   ev_t        exp_q[$];
   logic [6:0] m_addr, m_char_addr;
   logic [7:0] m_cmd, m_char_data;
   logic       m_inc, m_disp, m_cur, m_blink, m_two;
   logic [7:0] m_shadow [32];
   int         busy_until;
   int         last_e;

   function automatic logic [6:0] next_addr(input logic [6:0] a, input logic up);
      int v;
      if (up) begin
         if (a == 7'h27) return 7'h40;
         if (a == 7'h67) return 7'h00;
         v = (int'(a) + 1) % 128;
      end else begin
         if (a == 7'h40) return 7'h27;
         if (a == 7'h00) return 7'h67;
         v = (int'(a) + 127) % 128;
      end
      return 7'(v);
   endfunction

   function automatic void model_reset();
      m_addr = '0; m_char_addr = '0; m_cmd = '0; m_char_data = '0;
      m_inc = 1'b1; m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0; m_two = 1'b0;
      busy_until = 0;
   endfunction

   // Strobe whose effect lands on clock edge e
   function automatic void model_strobe(input int e, input bit s_rs, input bit s_rw,
                                        input logic [7:0] d, input int w);
      ev_t ev;
      int  idx;
      ev.at = e; ev.d = d; ev.a = m_addr; ev.bsy = (e < busy_until); ev.kind = '0;
      if (TCHK && (w < int'(MIN_EN_HIGH))) begin
         ev.kind = K_PERR;
      end else if (s_rw) begin
         ev.kind = K_RW;
      end else if (e <= busy_until) begin
         if (!TCHK) return;
         ev.kind = K_BERR;
      end else if (!s_rs) begin
         ev.kind = K_CMD;
         m_cmd   = d;
         if (d >= 8'h80)      m_addr = d[6:0];
         else if (d >= 8'h40) begin end
         else if (d >= 8'h20) m_two = d[3];
         else if (d >= 8'h10) begin if (!d[3]) m_addr = next_addr(m_addr, d[2]); end
         else if (d >= 8'h08) begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
         else if (d >= 8'h04) m_inc = d[1];
         else if (d >= 8'h02) m_addr = '0;
         else if (d == 8'h01) begin m_addr = '0; m_inc = 1'b1; end
         if (d == 8'h01) begin
            busy_until = e + int'(CLEAR_CYCLES);
            for (int i = 0; i < 32; i++) m_shadow[i] = 8'h20;
            ev.bsy = 1'b1;
         end else if (TCHK) begin
            busy_until = e + int'(BUSY_CYCLES);
            ev.bsy = 1'b1;
         end
      end else begin
         ev.kind     = K_CHR;
         m_char_data = d;
         m_char_addr = m_addr;
         if (m_addr <= 7'h0F || (m_addr >= 7'h40 && m_addr <= 7'h4F)) begin
            idx = (m_addr >= 7'h40 ? 16 : 0) + int'(m_addr) % 16;
            m_shadow[idx] = d;
         end
         m_addr = next_addr(m_addr, m_inc);
         if (TCHK) begin
            busy_until = e + int'(BUSY_CYCLES);
            ev.bsy = 1'b1;
         end
      end
      exp_q.push_back(ev);
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : monitor
      logic [4:0] obs;
      ev_t        ev;
      obs = {pulse_err, busy_err, rw_seen, char_valid, cmd_valid};
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
         check("missed_event", 32'd0, 32'(exp_q[0].kind));
         void'(exp_q.pop_front());
      end
      if (obs != 5'd0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", 32'(obs), 32'd0);
         end else begin
            ev = exp_q.pop_front();
            check("event_kind", 32'(obs), 32'(ev.kind));
            check("event_cycle", 32'(cyc), 32'(ev.at));
            check("busy_at_event", 32'(busy), 32'(ev.bsy));
            if (ev.kind == K_CMD) check("cmd_code", 32'(cmd_code), 32'(ev.d));
            if (ev.kind == K_CHR) begin
               check("char_data", 32'(char_data), 32'(ev.d));
               check("char_addr", 32'(char_addr), 32'(ev.a));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_strobe(input bit s_rs, input bit s_rw, input logic [7:0] d, input int w);
      @(posedge clk); #1;
      rs = s_rs; rw = s_rw; data = d; enable = 1'b1;
      repeat (w) @(posedge clk);
      #1 enable = 1'b0;
      last_e = cyc + 1 + 3;
      model_strobe(last_e, s_rs, s_rw, d, w);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_state();
      check("addr", 32'(addr), 32'(m_addr));
      check("display_on", 32'(display_on), 32'(m_disp));
      check("cursor_on", 32'(cursor_on), 32'(m_cur));
      check("blink_on", 32'(blink_on), 32'(m_blink));
      check("entry_inc", 32'(entry_inc), 32'(m_inc));
      check("two_line", 32'(two_line), 32'(m_two));
      check("busy_idle", 32'(busy), 32'(cyc < busy_until));
      check("cmd_code_held", 32'(cmd_code), 32'(m_cmd));
      check("char_data_held", 32'(char_data), 32'(m_char_data));
      check("char_addr_held", 32'(char_addr), 32'(m_char_addr));
   endtask

   task automatic check_shadow(input int i);
      @(posedge clk); #1 rd_idx = 5'(i);
      @(posedge clk); #1;
      check($sformatf("shadow[%0d]", i), 32'(rd_char), 32'(m_shadow[i]));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [7:0] saved [32];
      reset = 1'b1; rs = 1'b0; rw = 1'b0; enable = 1'b0; data = '0; rd_idx = '0;
      model_reset();
      for (int i = 0; i < 32; i++) m_shadow[i] = 8'h00;
      idle(3);
      check("rst_rd_char", 32'(rd_char), 32'd0);
      check("rst_pulses", 32'({pulse_err, busy_err, rw_seen, char_valid, cmd_valid}), 32'd0);
      check_state();
      reset = 1'b0;
      idle(2);

      // Initialisation sequence ending in clear
      do_strobe(0, 0, 8'h38, 6); idle(50);
      do_strobe(0, 0, 8'h0C, 6); idle(50);
      do_strobe(0, 0, 8'h06, 6); idle(50);
      do_strobe(0, 0, 8'h01, 6); idle(50);
      check_state();
      check("tp_two_line", 32'(two_line), 32'd1);
      check("tp_display_on", 32'(display_on), 32'd1);
      for (int i = 0; i < 32; i++) check_shadow(i);

      // Line 0 writes
      do_strobe(0, 0, 8'h80, 6); idle(20);
      do_strobe(1, 0, 8'h41, 6); idle(20);
      do_strobe(1, 0, 8'h42, 6); idle(20);
      check("tp_addr_ab", 32'(addr), 32'h02);
      check_shadow(0); check_shadow(1);

      // End of line 0 wraps to line 1
      do_strobe(0, 0, 8'hA7, 6); idle(20);
      do_strobe(1, 0, 8'h5A, 6); idle(20);
      check("tp_char_addr_27", 32'(char_addr), 32'h27);
      check("tp_addr_40", 32'(addr), 32'h40);
      do_strobe(1, 0, 8'h5B, 6); idle(20);
      check_shadow(16);

      // Decrement mode wrap and last entry
      do_strobe(0, 0, 8'h04, 6); idle(20);
      do_strobe(0, 0, 8'h80, 6); idle(20);
      do_strobe(1, 0, 8'h31, 6); idle(20);
      check("tp_addr_67", 32'(addr), 32'h67);
      do_strobe(0, 0, 8'hCF, 6); idle(20);
      do_strobe(1, 0, 8'h32, 6); idle(20);
      check_shadow(31); check_shadow(0);
      check_state();

      // Short pulse, back-to-back strobes, read strobe
      do_strobe(1, 0, 8'h41, 2); idle(20);
      do_strobe(1, 0, 8'h43, 6); idle(1);
      do_strobe(1, 0, 8'h44, 4); idle(20);
      do_strobe(0, 1, 8'h55, 6); idle(20);
      check_state();

      // Reset in the 10th cycle of clear
      saved = m_shadow;
      do_strobe(0, 0, 8'h01, 6);
      while (cyc < last_e + 9) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      check("busy_after_reset", 32'(busy), 32'd0);
      reset = 1'b0;
      model_reset();
      m_shadow = saved;
      for (int i = 0; i < 9; i++) m_shadow[i] = 8'h20;
      check_state();
      check_shadow(0); check_shadow(8); check_shadow(31);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         bit         r_rw, r_rs;
         logic [7:0] d;
         r_rw = ($urandom_range(0, 99) < 8);
         r_rs = 1'($urandom_range(0, 1));
         d    = 8'($urandom);
         if (!r_rs && !r_rw && ($urandom_range(0, 9) == 0)) d = 8'h01;
         do_strobe(r_rs, r_rw, d, int'($urandom_range(1, 7)));
         repeat ($urandom_range(0, 25)) @(posedge clk);
      end
      idle(60);
      check_state();
      for (int i = 0; i < 32; i++) check_shadow(i);
      idle(5);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
